pic_host_bus_master: RTL and testbench

- CPU-side master for the 8259A pin interface: the other end of the PIC's RD_n/WR_n/A0/CS_n/INTA_n/INT/D protocol.
- Turns single-beat host commands into timed PIC register writes (ICW/OCW) and reads (IRR/ISR/IMR).
- Detects INT and autonomously runs the 8086-style two-pulse INTA_n acknowledge, capturing the vector byte.
- Sits between the testbench/system CPU model and the PIC top; the PIC D bus is split here into out/oe/in.

---
 rtl/pic_host_bus_master.sv | 200 ++++++++++++++++++++
 tb/tb_pic_host_bus_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_host_bus_master.sv
// CPU-side master for the 8259A pin interface: turns host commands into timed
// register accesses and runs the two-pulse INTA acknowledge on INT.
module pic_host_bus_master #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned SETUP_W = 1,
    parameter int unsigned GAP_W   = 2
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       inta_en,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       busy,
    input  logic       INT,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in,
    output logic       CS_n,
    output logic       A0,
    output logic       RD_n,
    output logic       WR_n,
    output logic       INTA_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_INTA1,
        S_INTA_GAP,
        S_INTA2,
        S_RECOVER
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             int_meta, int_s;
    logic             inta_en_q;
    logic             lat_write, lat_a0;
    logic [7:0]       lat_data;

    logic             accept;
    logic             rd_sample, vec_sample, rsp_pulse;
    logic             eff_write, eff_a0;
    logic [7:0]       eff_data;
    logic             access_nxt;
    logic             cmd_ready_nxt;

    // Next-state, cycle counter and next values of the registered pins
    always_comb begin
        next_state = state;
        cnt_nxt    = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        accept     = 1'b0;
        rd_sample  = 1'b0;
        vec_sample = 1'b0;
        rsp_pulse  = 1'b0;

        case (state)
            S_IDLE: begin
                if (int_s && inta_en_q) begin
                    next_state = S_INTA1;
                    cnt_nxt    = PULSE_LD;
                end else if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    next_state = S_SETUP;
                    cnt_nxt    = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    next_state = S_STROBE;
                    cnt_nxt    = PULSE_LD;
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    rd_sample  = !lat_write;
                    next_state = S_HOLD;
                    cnt_nxt    = SETUP_LD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    rsp_pulse  = !lat_write;
                    next_state = S_IDLE;
                end
            end
            S_INTA1: begin
                if (cnt == '0) begin
                    next_state = S_INTA_GAP;
                    cnt_nxt    = GAP_LD;
                end
            end
            S_INTA_GAP: begin
                if (cnt == '0) begin
                    next_state = S_INTA2;
                    cnt_nxt    = PULSE_LD;
                end
            end
            S_INTA2: begin
                if (cnt == '0) begin
                    vec_sample = 1'b1;
                    next_state = S_RECOVER;
                    cnt_nxt    = '0;
                end
            end
            S_RECOVER: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
                cnt_nxt    = '0;
            end
        endcase

        eff_write  = accept ? cmd_write : lat_write;
        eff_a0     = accept ? cmd_a0    : lat_a0;
        eff_data   = accept ? cmd_data  : lat_data;
        access_nxt = (next_state == S_SETUP) || (next_state == S_STROBE) ||
                     (next_state == S_HOLD);
        // int_meta and inta_en become next cycle's int_s and inta_en_q, so the
        // registered ready exactly mirrors the arbitration IDLE will make.
        cmd_ready_nxt = (next_state == S_IDLE) && !(int_meta && inta_en);
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // INT synchroniser, command latch and registered pin/handshake outputs
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            int_meta  <= 1'b0;
            int_s     <= 1'b0;
            inta_en_q <= 1'b0;
            lat_write <= 1'b0;
            lat_a0    <= 1'b0;
            lat_data  <= 8'h00;
            CS_n      <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            INTA_n    <= 1'b1;
            A0        <= 1'b0;
            D_oe      <= 1'b0;
            D_out     <= 8'h00;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= 8'h00;
            vec_data  <= 8'h00;
        end else begin
            int_meta  <= INT;
            int_s     <= int_meta;
            inta_en_q <= inta_en;
            if (accept) begin
                lat_write <= cmd_write;
                lat_a0    <= cmd_a0;
                lat_data  <= cmd_data;
            end
            CS_n      <= !access_nxt;
            A0        <= access_nxt ? eff_a0 : A0;
            D_oe      <= access_nxt && eff_write;
            D_out     <= (access_nxt && eff_write) ? eff_data : D_out;
            WR_n      <= !((next_state == S_STROBE) && eff_write);
            RD_n      <= !((next_state == S_STROBE) && !eff_write);
            INTA_n    <= !((next_state == S_INTA1) || (next_state == S_INTA2));
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_pulse;
            vec_valid <= (next_state == S_RECOVER);
            busy      <= (next_state != S_IDLE);
            if (rd_sample) begin
                rsp_data <= D_in;
            end
            if (vec_sample) begin
                vec_data <= D_in;
            end
        end
    end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: register write/read timing, INTA
// sequence, arbitration against a pending command, and mid-cycle reset.
module tb_pic_host_bus_master;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       inta_en, vec_valid;
    logic [7:0] vec_data;
    logic       busy, INT;
    logic [7:0] D_out, D_in;
    logic       D_oe, CS_n, A0, RD_n, WR_n, INTA_n;

    int checks = 0;
    int errors = 0;

    int cs_low, wr_low, rd_low, inta_low, busy_cnt, inta_falls;
    int fall1, fall2, cs_first, wr_first, wr_last, rd_first, ready_cyc;
    int rsp_pulses, rsp_cyc, vec_pulses, vec_cyc, bus_bad, multi;
    logic       inta_prev, acc_pend;
    logic       exp_oe, exp_a0;
    logic [7:0] exp_dout;

    pic_host_bus_master dut (
        .CLK(CLK), .RST_n(RST_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inta_en(inta_en), .vec_valid(vec_valid), .vec_data(vec_data),
        .busy(busy), .INT(INT),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .CS_n(CS_n), .A0(A0), .RD_n(RD_n), .WR_n(WR_n), .INTA_n(INTA_n)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command at a negedge once ready; returns just after the accepting edge.
    task automatic do_cmd(input logic wr, input logic a, input logic [7:0] d);
        int w;
        w = 0;
        @(negedge CLK);
        while (!cmd_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_write = wr;
        cmd_a0    = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    // Observe n cycles at negedges, gathering pin statistics; cycle 1 is the
    // first negedge after the call. Also drives INT drop, vector byte, late cmd.
    task automatic mon(input int n, input int drop_mode, input logic [7:0] vec_byte,
                       input int cmd_at);
        cs_low = 0; wr_low = 0; rd_low = 0; inta_low = 0; busy_cnt = 0;
        inta_falls = 0; fall1 = 0; fall2 = 0; cs_first = 0; wr_first = 0;
        wr_last = 0; rd_first = 0; ready_cyc = 0; rsp_pulses = 0; rsp_cyc = 0;
        vec_pulses = 0; vec_cyc = 0; bus_bad = 0; multi = 0;
        inta_prev = INTA_n; acc_pend = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (!CS_n) begin
                cs_low++;
                if (cs_first == 0) cs_first = i;
                if (D_oe !== exp_oe || (exp_oe && D_out !== exp_dout) || A0 !== exp_a0)
                    bus_bad++;
            end else if (D_oe !== 1'b0) begin
                bus_bad++;
            end
            if (!WR_n) begin
                wr_low++;
                if (wr_first == 0) wr_first = i;
                wr_last = i;
            end
            if (!RD_n) begin
                rd_low++;
                if (rd_first == 0) rd_first = i;
            end
            if (!INTA_n) begin
                inta_low++;
                if (inta_prev) begin
                    inta_falls++;
                    if (inta_falls == 1) fall1 = i;
                    if (inta_falls == 2) fall2 = i;
                end
            end
            inta_prev = INTA_n;
            if (busy) busy_cnt++;
            if ((int'(!WR_n) + int'(!RD_n) + int'(!INTA_n)) > 1 ||
                (D_oe && (!RD_n || !INTA_n)))
                multi++;
            if (rsp_valid) begin rsp_pulses++; rsp_cyc = i; end
            if (vec_valid) begin vec_pulses++; vec_cyc = i; end
            if (cmd_ready && ready_cyc == 0 && (cmd_at == 0 || i >= cmd_at)) ready_cyc = i;

            if (drop_mode == 1 && inta_falls == 1) INT = 1'b0;
            if (drop_mode == 2 && inta_falls == 1 && INTA_n) INT = 1'b0;
            if (inta_falls == 2) D_in = vec_byte;
            if (acc_pend) begin cmd_valid = 1'b0; acc_pend = 1'b0; end
            if (cmd_at != 0 && i == cmd_at) cmd_valid = 1'b1;
            if (cmd_valid && cmd_ready) acc_pend = 1'b1;
        end
    endtask

    initial begin
        RST_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0;
        cmd_data = 8'h00; inta_en = 1'b0; INT = 1'b0; D_in = 8'h00;
        exp_oe = 1'b0; exp_a0 = 1'b0; exp_dout = 8'h00;
        repeat (3) @(negedge CLK);

        chk("rst_cs_n", 32'(CS_n), 32'd1);
        chk("rst_rd_n", 32'(RD_n), 32'd1);
        chk("rst_wr_n", 32'(WR_n), 32'd1);
        chk("rst_inta_n", 32'(INTA_n), 32'd1);
        chk("rst_d_oe", 32'(D_oe), 32'd0);
        chk("rst_d_out", 32'(D_out), 32'd0);
        chk("rst_a0", 32'(A0), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_vec_data", 32'(vec_data), 32'd0);

        RST_n = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // ICW1 write: a0=0, data 0x13
        exp_oe = 1'b1; exp_dout = 8'h13; exp_a0 = 1'b0;
        do_cmd(1'b1, 1'b0, 8'h13);
        mon(10, 0, 8'h00, 0);
        chk("wr_cs_low", 32'(cs_low), 32'd6);
        chk("wr_cs_first", 32'(cs_first), 32'd1);
        chk("wr_strobe_len", 32'(wr_low), 32'd4);
        chk("wr_strobe_first", 32'(wr_first), 32'd2);
        chk("wr_strobe_last", 32'(wr_last), 32'd5);
        chk("wr_ready_again", 32'(ready_cyc), 32'd7);
        chk("wr_busy_len", 32'(busy_cnt), 32'd6);
        chk("wr_bus", 32'(bus_bad), 32'd0);
        chk("wr_no_rd", 32'(rd_low), 32'd0);
        chk("wr_no_rsp", 32'(rsp_pulses), 32'd0);
        chk("wr_exclusive", 32'(multi), 32'd0);

        // Register read: a0=1, PIC drives 0xA5
        D_in = 8'hA5; exp_oe = 1'b0; exp_a0 = 1'b1;
        do_cmd(1'b0, 1'b1, 8'h00);
        mon(10, 0, 8'h00, 0);
        chk("rd_strobe_len", 32'(rd_low), 32'd4);
        chk("rd_strobe_first", 32'(rd_first), 32'd2);
        chk("rd_no_wr", 32'(wr_low), 32'd0);
        chk("rd_bus", 32'(bus_bad), 32'd0);
        chk("rd_rsp_pulses", 32'(rsp_pulses), 32'd1);
        chk("rd_rsp_cycle", 32'(rsp_cyc), 32'd7);
        chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
        chk("rd_exclusive", 32'(multi), 32'd0);

        // Interrupt acknowledge; INT released once the first pulse is seen
        D_in = 8'hEE; inta_en = 1'b1; INT = 1'b1;
        mon(20, 1, 8'h4B, 0);
        chk("inta_pulses", 32'(inta_falls), 32'd2);
        chk("inta_first_fall", 32'(fall1), 32'd3);
        chk("inta_pulse_spacing", 32'(fall2 - fall1), 32'd6);
        chk("inta_low_total", 32'(inta_low), 32'd8);
        chk("inta_vec_pulses", 32'(vec_pulses), 32'd1);
        chk("inta_vec_cycle", 32'(vec_cyc), 32'd13);
        chk("inta_vec_data", 32'(vec_data), 32'h4B);
        chk("inta_cs_high", 32'(cs_low), 32'd0);
        chk("inta_no_rdwr", 32'(wr_low + rd_low), 32'd0);
        chk("inta_bus", 32'(bus_bad), 32'd0);
        chk("inta_exclusive", 32'(multi), 32'd0);

        // INT drops during the gap: sequence still completes, no restart
        D_in = 8'hEE; INT = 1'b1;
        mon(25, 2, 8'h5F, 0);
        chk("gap_pulses", 32'(inta_falls), 32'd2);
        chk("gap_low_total", 32'(inta_low), 32'd8);
        chk("gap_vec_pulses", 32'(vec_pulses), 32'd1);
        chk("gap_vec_cycle", 32'(vec_cyc), 32'd13);
        chk("gap_vec_data", 32'(vec_data), 32'h5F);

        // Command pending while INTA is arbitrated: INTA first, then the write
        D_in = 8'hEE; INT = 1'b1;
        cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h5A;
        exp_oe = 1'b1; exp_dout = 8'h5A; exp_a0 = 1'b1;
        mon(32, 1, 8'h21, 2);
        chk("arb_inta_first_fall", 32'(fall1), 32'd3);
        chk("arb_inta_pulses", 32'(inta_falls), 32'd2);
        chk("arb_vec_cycle", 32'(vec_cyc), 32'd13);
        chk("arb_vec_data", 32'(vec_data), 32'h21);
        chk("arb_ready_cycle", 32'(ready_cyc), 32'd14);
        chk("arb_cs_first", 32'(cs_first), 32'd15);
        chk("arb_wr_first", 32'(wr_first), 32'd16);
        chk("arb_wr_len", 32'(wr_low), 32'd4);
        chk("arb_cs_low", 32'(cs_low), 32'd6);
        chk("arb_bus", 32'(bus_bad), 32'd0);
        chk("arb_exclusive", 32'(multi), 32'd0);
        chk("arb_cmd_taken", 32'(cmd_valid), 32'd0);
        inta_en = 1'b0;

        // Reset while WR_n is low
        D_in = 8'h00;
        do_cmd(1'b1, 1'b0, 8'h77);
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_wr_low", 32'(WR_n), 32'd0);
        RST_n = 1'b0;
        @(negedge CLK);
        chk("mid_rst_wr_n", 32'(WR_n), 32'd1);
        chk("mid_rst_cs_n", 32'(CS_n), 32'd1);
        chk("mid_rst_rd_inta", 32'({RD_n, INTA_n}), 32'd3);
        chk("mid_rst_d_oe", 32'(D_oe), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pulses", 32'({rsp_valid, vec_valid}), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_vec_data", 32'(vec_data), 32'd0);
        RST_n = 1'b1;
        mon(8, 0, 8'h00, 0);
        chk("post_rst_ready", 32'(ready_cyc), 32'd1);
        chk("post_rst_idle_pins", 32'(wr_low + cs_low + rsp_pulses + vec_pulses), 32'd0);

        // Normal operation resumes
        D_in = 8'h3C; exp_oe = 1'b0; exp_a0 = 1'b0;
        do_cmd(1'b0, 1'b0, 8'h00);
        mon(10, 0, 8'h00, 0);
        chk("resume_rd_len", 32'(rd_low), 32'd4);
        chk("resume_rsp_pulses", 32'(rsp_pulses), 32'd1);
        chk("resume_rsp_data", 32'(rsp_data), 32'h3C);
        chk("resume_bus", 32'(bus_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
